// File: rtl/seq_trigger_mc.sv
// Multi-channel arm/complete trigger with per-channel expiry, completion mask and hit counter.
// Optional per-channel expiry is enabled by defining SEQ_TRIG_TIMEOUT_EN.
module seq_trigger_mc #(
    parameter int NCH     = 4,
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   load_mem,
    input  logic [NCH-1:0]   done,
    input  logic             clr,
    output logic [NCH-1:0]   ready,
    output logic             ready2,
    output logic [NCH-1:0]   timeout,
    output logic [CNT_W-1:0] hit_cnt
);

    typedef enum logic {IDLE, ARMED} state_t;

    localparam int PW = $clog2(NCH + 1);
    localparam int SW = CNT_W + 5;

    // Completion events as they are being registered into ready
    logic [NCH-1:0] rdy_set;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t st_q;
        logic   rdy_q;

        assign rdy_set[i] = (st_q == ARMED) && done[i];
        assign ready[i]   = rdy_q;

`ifdef SEQ_TRIG_TIMEOUT_EN
        localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
        logic [CW-1:0] cnt_q;
        logic          to_q;
        logic          expire;

        // Expiry lands the timeout pulse TIMEOUT cycles after the arming cycle
        assign expire     = (int'(cnt_q) + 2 >= TIMEOUT);
        assign timeout[i] = to_q;
`else
        assign timeout[i] = 1'b0;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q  <= IDLE;
                rdy_q <= 1'b0;
`ifdef SEQ_TRIG_TIMEOUT_EN
                cnt_q <= '0;
                to_q  <= 1'b0;
`endif
            end else begin
                rdy_q <= 1'b0;
`ifdef SEQ_TRIG_TIMEOUT_EN
                to_q  <= 1'b0;
`endif
                unique case (st_q)
                    IDLE: begin
                        if (load_mem[i]) begin
                            st_q <= ARMED;
`ifdef SEQ_TRIG_TIMEOUT_EN
                            cnt_q <= '0;
`endif
                        end
                    end
                    ARMED: begin
                        if (done[i]) begin
                            rdy_q <= 1'b1;
                            if (!load_mem[i]) st_q <= IDLE;
`ifdef SEQ_TRIG_TIMEOUT_EN
                            cnt_q <= '0;
`endif
                        end else if (load_mem[i]) begin
`ifdef SEQ_TRIG_TIMEOUT_EN
                            cnt_q <= '0;
`endif
                        end
`ifdef SEQ_TRIG_TIMEOUT_EN
                        else if (expire) begin
                            to_q <= 1'b1;
                            st_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`endif
                    end
                    default: st_q <= IDLE;
                endcase
            end
        end
    end

    logic [NCH-1:0]   mask_q;
    logic             ready2_q;
    logic [CNT_W-1:0] hit_q;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] hit_d;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NCH; i++) begin
            pop = pop + PW'(rdy_set[i]);
        end
    end

    assign sum   = SW'(hit_q) + SW'(pop);
    assign hit_d = (sum[SW-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q   <= '0;
            ready2_q <= 1'b0;
            hit_q    <= '0;
        end else if (clr) begin
            mask_q   <= '0;
            ready2_q <= 1'b0;
            hit_q    <= '0;
        end else begin
            mask_q   <= mask_q | rdy_set;
            ready2_q <= &mask_q;
            hit_q    <= hit_d;
        end
    end

    assign ready2  = ready2_q;
    assign hit_cnt = hit_q;

endmodule

// File: tb/tb_seq_trigger_mc.sv
// Randomized and directed checks of seq_trigger_mc against a cycle-indexed reference model.
// Two instances share stimulus: CNT_W=8 and CNT_W=2 (saturation).
module tb_seq_trigger_mc;

    localparam int NCH     = 4;
    localparam int TIMEOUT = 8;
    localparam int TLAT    = (TIMEOUT < 2) ? 2 : TIMEOUT;
`ifdef SEQ_TRIG_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] load_mem;
    logic [NCH-1:0] done;
    logic           clr;

    logic [NCH-1:0] ready_a, timeout_a, ready_b, timeout_b;
    logic           ready2_a, ready2_b;
    logic [7:0]     hit_a;
    logic [1:0]     hit_b;

    int n_checks = 0;
    int n_errors = 0;

    seq_trigger_mc #(.NCH(NCH), .TIMEOUT(TIMEOUT), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .load_mem(load_mem), .done(done), .clr(clr),
        .ready(ready_a), .ready2(ready2_a), .timeout(timeout_a), .hit_cnt(hit_a)
    );

    seq_trigger_mc #(.NCH(NCH), .TIMEOUT(TIMEOUT), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .load_mem(load_mem), .done(done), .clr(clr),
        .ready(ready_b), .ready2(ready2_b), .timeout(timeout_b), .hit_cnt(hit_b)
    );

    always #5 clk = ~clk;

    // Reference model: each channel holds whether it is waiting and the absolute
    // cycle at which its expiry pulse would be visible.
    int         cyc;
    bit         m_armed [NCH];
    int         m_dl    [NCH];
    logic [3:0] e_ready, e_to;
    bit         e_r2;
    bit   [3:0] m_mask;
    int         m_hit;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_armed[i] = 1'b0;
            m_dl[i]    = 0;
        end
        e_ready = '0;
        e_to    = '0;
        e_r2    = 1'b0;
        m_mask  = '0;
        m_hit   = 0;
    endtask

    task automatic model_update(input logic [3:0] ld, input logic [3:0] dn, input logic cl);
        int pop;
        pop = 0;
        for (int i = 0; i < NCH; i++) begin
            e_ready[i] = 1'b0;
            e_to[i]    = 1'b0;
            if (m_armed[i]) begin
                if (dn[i]) begin
                    e_ready[i] = 1'b1;
                    pop++;
                    m_armed[i] = ld[i];
                    m_dl[i]    = cyc + TLAT;
                end else if (ld[i]) begin
                    m_dl[i] = cyc + TLAT;
                end else if (TO_EN && (cyc + 1 == m_dl[i])) begin
                    e_to[i]    = 1'b1;
                    m_armed[i] = 1'b0;
                end
            end else if (ld[i]) begin
                m_armed[i] = 1'b1;
                m_dl[i]    = cyc + TLAT;
            end
        end
        if (cl) begin
            e_r2   = 1'b0;
            m_mask = '0;
            m_hit  = 0;
        end else begin
            e_r2   = (m_mask == 4'hf);
            m_mask = m_mask | e_ready;
            m_hit  = m_hit + pop;
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"},    32'(ready_a),   32'(e_ready));
        chk({tag, ".timeout"},  32'(timeout_a), 32'(e_to));
        chk({tag, ".ready2"},   32'(ready2_a),  32'(e_r2));
        chk({tag, ".hit8"},     32'(hit_a),     32'((m_hit > 255) ? 255 : m_hit));
        chk({tag, ".ready_s"},  32'(ready_b),   32'(e_ready));
        chk({tag, ".timeout_s"},32'(timeout_b), 32'(e_to));
        chk({tag, ".hit2"},     32'(hit_b),     32'((m_hit > 3) ? 3 : m_hit));
    endtask

    // Drive one cycle of inputs, let the edge sample them, then compare.
    task automatic step(input logic [3:0] ld, input logic [3:0] dn, input logic cl);
        load_mem = ld;
        done     = dn;
        clr      = cl;
        @(posedge clk);
        model_update(ld, dn, cl);
        #1;
        check_all("step");
    endtask

    initial begin
        rst      = 1'b1;
        load_mem = '0;
        done     = '0;
        clr      = 1'b0;
        cyc      = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Single completion: arm at 0, done at 3, ready at 4 only
        step(4'b0001, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);
        chk("basic_ready", 32'(ready_a), 32'h1);
        chk("basic_hit", 32'(hit_a), 32'h1);
        step(4'b0000, 4'b0000, 1'b0);
        chk("basic_ready_gone", 32'(ready_a), 32'h0);

        // Expiry of channel 1 at cycle 8
        step(4'b0010, 4'b0000, 1'b0);
        repeat (6) step(4'b0000, 4'b0000, 1'b0);
        chk("expire_early", 32'(timeout_a), 32'h0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("expire_pulse", 32'(timeout_a), TO_EN ? 32'h2 : 32'h0);
        chk("expire_no_ready", 32'(ready_a[1]), 32'h0);
        step(4'b0000, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);

        // Re-arm of channel 2 at 5 pushes expiry from 8 to 13
        step(4'b0100, 4'b0000, 1'b0);
        repeat (4) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0100, 4'b0000, 1'b0);
        repeat (2) step(4'b0000, 4'b0000, 1'b0);
        chk("rearm_not8", 32'(timeout_a), 32'h0);
        repeat (4) step(4'b0000, 4'b0000, 1'b0);
        chk("rearm_not12", 32'(timeout_a), 32'h0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("rearm_13", 32'(timeout_a), TO_EN ? 32'h4 : 32'h0);
        step(4'b0000, 4'b0100, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);

        // Done in the last waiting cycle wins over expiry
        step(4'b1000, 4'b0000, 1'b0);
        repeat (6) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b1000, 1'b0);
        chk("race_ready", 32'(ready_a), 32'h8);
        chk("race_no_timeout", 32'(timeout_a), 32'h0);
        step(4'b0000, 4'b0000, 1'b0);

        // All-channel mask: ready at 2,4,6,9 -> ready2 at 10; clr at 12
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0111, 4'b0000, 1'b0);
        step(4'b0000, 4'b0001, 1'b0);
        step(4'b1000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0010, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0100, 1'b0);
        repeat (2) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b1000, 1'b0);
        chk("mask_r2_low", 32'(ready2_a), 32'h0);
        step(4'b0000, 4'b0000, 1'b0);
        chk("mask_r2_high", 32'(ready2_a), 32'h1);
        repeat (2) step(4'b0000, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b1);
        chk("clr_r2", 32'(ready2_a), 32'h0);
        chk("clr_hit", 32'(hit_a), 32'h0);

        // Five completions on one channel via load+done: saturate the 2-bit counter
        step(4'b0001, 4'b0000, 1'b0);
        repeat (5) step(4'b0001, 4'b0001, 1'b0);
        chk("sat_hit8", 32'(hit_a), 32'd5);
        chk("sat_hit2", 32'(hit_b), 32'd3);

        // Asynchronous reset while channels are waiting
        step(4'b1110, 4'b0000, 1'b0);
        step(4'b0000, 4'b0000, 1'b0);
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(4'b0000, 4'b0000, 1'b0);
            chk("rst_no_ready", 32'(ready_a), 32'h0);
            chk("rst_no_timeout", 32'(timeout_a), 32'h0);
        end

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [3:0] ld, dn;
            logic       cl;
            ld = 4'($urandom & $urandom);
            dn = 4'($urandom & $urandom);
            cl = ($urandom_range(0, 31) == 0);
            step(ld, dn, cl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_trigger_mc.md
SEQ_TRIGGER_MC -- requirements
Module: seq_trigger_mc

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent trigger channels (1..16).
REQ-002 SHALL have parameter TIMEOUT, default 8, meaning the cycles an armed channel waits for done before expiring (1..255).
REQ-003 SHALL have parameter CNT_W, default 8, meaning the width of the completion counter.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning an asynchronous, active-high reset.
REQ-006 SHALL have port load_mem, input, NCH, meaning a per-channel arm request, sampled each cycle.
REQ-007 SHALL have port done, input, NCH, meaning a per-channel completion event, sampled each cycle.
REQ-008 SHALL have port clr, input, 1, meaning a synchronous clear of the ready2 mask and hit_cnt.
REQ-009 SHALL have port ready, output, NCH, meaning a one-cycle pulse per channel on sequence completion.
REQ-010 SHALL have port ready2, output, 1, meaning a level that is high once every channel has completed at least once since the last reset or clr.
REQ-011 SHALL have port timeout, output, NCH, meaning a one-cycle pulse per channel on expiry.
REQ-012 SHALL have port hit_cnt, output, CNT_W, meaning the total completions across all channels, saturating.

Function
REQ-013 Each channel SHALL run a two-state FSM (IDLE, ARMED) with a private wait counter sized for TIMEOUT.
REQ-014 IDLE with load_mem[i]=1 SHALL go to ARMED with the counter at 0; done[i] in IDLE SHALL be ignored.
REQ-015 ARMED with done[i]=1 SHALL drive ready[i]=1 in the next cycle and return to IDLE.
REQ-016 ARMED without done[i] SHALL increment the counter each cycle.
REQ-017 When the counter reaches TIMEOUT-1 without done[i], the FSM SHALL drive timeout[i]=1 in the next cycle and return to IDLE.
REQ-018 ARMED with load_mem[i]=1 and done[i]=0 SHALL restart the counter at 0 (re-arm) and SHALL NOT pulse any output.
REQ-019 ARMED with load_mem[i]=1 and done[i]=1 SHALL pulse ready[i], stay ARMED and reset the counter to 0.
REQ-020 If done[i] arrives in the same cycle the counter reaches TIMEOUT-1, done SHALL win: ready[i] pulses and timeout[i] does not.
REQ-021 ready and timeout SHALL be registered, with one-cycle latency from the sampled event; they are never both high on one channel.
REQ-022 Each ready[i] pulse SHALL set mask bit i; ready2 SHALL be registered AND of the mask, so it rises the cycle after the last missing bit is set.
REQ-023 hit_cnt SHALL add the popcount of the ready pulses in each cycle, saturating at 2^CNT_W-1 with no wrap.
REQ-024 clr=1 SHALL zero the mask, ready2 and hit_cnt next cycle; ready pulses in that cycle are discarded from the count; channel FSMs are unaffected.

Reset
REQ-025 While rst=1, all FSMs SHALL be IDLE, all counters and the mask SHALL be 0, and ready, ready2, timeout and hit_cnt SHALL be 0, asynchronously.
REQ-026 rst asserted mid-sequence SHALL abort all ARMED channels without pulsing; operation SHALL resume on the first rising edge after rst falls.

Configuration
REQ-027 With macro SEQ_TRIG_TIMEOUT_EN defined, REQ-017 and REQ-020 SHALL apply and timeout SHALL be driven.
REQ-028 Without SEQ_TRIG_TIMEOUT_EN, an ARMED channel SHALL wait indefinitely, no wait counters SHALL be built, and timeout SHALL be tied to 0.

Verification
REQ-029 The bench SHALL check: load_mem[0]=1 at cycle 0, done[0]=1 at cycle 3 -> ready=4'b0001 at cycle 4 only, hit_cnt=1.
REQ-030 The bench SHALL check, with TIMEOUT=8 and SEQ_TRIG_TIMEOUT_EN: load_mem[1] at cycle 0, no done -> timeout[1] pulses at cycle 8, ready[1] stays 0.
REQ-031 The bench SHALL check: load_mem[2] at cycles 0 and 5, done absent -> timeout[2] at cycle 13, not 8.
REQ-032 The bench SHALL check: done[3] coincident with the counter at TIMEOUT-1 -> ready[3] pulses and timeout[3]=0.
REQ-033 The bench SHALL check: all four channels complete at cycles 2, 4, 6 and 9 -> ready2 rises at cycle 10; clr at 12 -> ready2=0 and hit_cnt=0 at 13.
REQ-034 The bench SHALL check, with CNT_W=2: five completions -> hit_cnt saturates at 3; rst mid-ARMED -> no ready or timeout pulse follows.
